// File: rtl/idu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : idu_pkg
//  Description : Shared encodings for the registered decode stage: ALU op,
//                immediate-format, write-back and next-PC codes, RV opcodes
//                and the packed control bundle carried to the EXU.
//  Revision    : 1.0 - initial release
// ============================================================================
package idu_pkg;

    // ALU operation classes
    localparam logic [3:0] c_alu_add   = 4'd0;
    localparam logic [3:0] c_alu_shift = 4'd1;
    localparam logic [3:0] c_alu_cmp   = 4'd2;
    localparam logic [3:0] c_alu_div   = 4'd3;
    localparam logic [3:0] c_alu_logic = 4'd4;
    localparam logic [3:0] c_alu_mul   = 4'd5;
    localparam logic [3:0] c_alu_auipc = 4'd6;
    localparam logic [3:0] c_alu_lui   = 4'd7;
    localparam logic [3:0] c_alu_none  = 4'd15;

    // Immediate formats
    localparam logic [2:0] c_sext_none = 3'd0;
    localparam logic [2:0] c_sext_i    = 3'd1;
    localparam logic [2:0] c_sext_u    = 3'd2;
    localparam logic [2:0] c_sext_s    = 3'd3;
    localparam logic [2:0] c_sext_j    = 3'd4;
    localparam logic [2:0] c_sext_b    = 3'd5;

    // Write-back source
    localparam logic [1:0] c_wb_alu = 2'd0;
    localparam logic [1:0] c_wb_mem = 2'd1;
    localparam logic [1:0] c_wb_pc4 = 2'd2;

    // Next-PC source
    localparam logic [1:0] c_npc_seq  = 2'd0;
    localparam logic [1:0] c_npc_br   = 2'd1;
    localparam logic [1:0] c_npc_jal  = 2'd2;
    localparam logic [1:0] c_npc_jalr = 2'd3;

    // Major opcodes
    localparam logic [6:0] c_opc_lui      = 7'b0110111;
    localparam logic [6:0] c_opc_auipc    = 7'b0010111;
    localparam logic [6:0] c_opc_jal      = 7'b1101111;
    localparam logic [6:0] c_opc_jalr     = 7'b1100111;
    localparam logic [6:0] c_opc_branch   = 7'b1100011;
    localparam logic [6:0] c_opc_load     = 7'b0000011;
    localparam logic [6:0] c_opc_store    = 7'b0100011;
    localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
    localparam logic [6:0] c_opc_op_imm32 = 7'b0011011;
    localparam logic [6:0] c_opc_op       = 7'b0110011;
    localparam logic [6:0] c_opc_op32     = 7'b0111011;
    localparam logic [6:0] c_opc_system   = 7'b1110011;

    localparam logic [6:0] c_f7_base   = 7'b0000000;
    localparam logic [6:0] c_f7_alt    = 7'b0100000;
    localparam logic [6:0] c_f7_muldiv = 7'b0000001;

    localparam logic [31:0] c_instr_ebreak = 32'h0010_0073;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [3:0] alu_sub;
        logic [2:0] sext_sel;
        logic       reg_we;
        logic       sel_rs1_pc;
        logic       sel_rs2_imm;
        logic [1:0] wb_sel;
        logic [1:0] npc_sel;
        logic       mem_re;
        logic       mem_we;
        logic [1:0] mem_size;
        logic       mem_uns;
        logic       word_op;
        logic       illegal;
        logic       ebreak;
    } ctrl_t;

    // ALU class of an integer op selected by funct3 alone
    function automatic logic [3:0] alu_of_f3(input logic [2:0] f3);
        logic [3:0] v_op;
        case (f3)
            3'b000:         v_op = c_alu_add;
            3'b001, 3'b101: v_op = c_alu_shift;
            3'b010, 3'b011: v_op = c_alu_cmp;
            default:        v_op = c_alu_logic;
        endcase
        return v_op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/idu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : idu_decode
//  Description : Combinational RV32I/RV64I instruction decoder producing the
//                ctrl_t bundle. Optional M extension under RV_M_EXT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module idu_decode
    import idu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    localparam logic c_rv64 = (XLEN == 64);
`ifdef RV_M_EXT_EN
    localparam logic c_m_ext = 1'b1;
`else
    localparam logic c_m_ext = 1'b0;
`endif

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_legal;

    assign w_opc = instr[6:0];
    assign w_f3  = instr[14:12];
    assign w_f7  = instr[31:25];

    // Classify the instruction, then collapse anything undecodable to the illegal bundle
    always_comb begin
        ctrl             = '0;
        ctrl.alu_op      = c_alu_add;
        ctrl.alu_sub     = {1'b0, w_f3};
        ctrl.sext_sel    = c_sext_none;
        ctrl.wb_sel      = c_wb_alu;
        ctrl.npc_sel     = c_npc_seq;
        w_legal          = 1'b0;
        case (w_opc)
            c_opc_lui: begin
                w_legal          = 1'b1;
                ctrl.alu_op      = c_alu_lui;
                ctrl.sext_sel    = c_sext_u;
                ctrl.reg_we      = 1'b1;
                ctrl.sel_rs2_imm = 1'b1;
            end
            c_opc_auipc: begin
                w_legal          = 1'b1;
                ctrl.alu_op      = c_alu_auipc;
                ctrl.sext_sel    = c_sext_u;
                ctrl.reg_we      = 1'b1;
                ctrl.sel_rs1_pc  = 1'b1;
                ctrl.sel_rs2_imm = 1'b1;
            end
            c_opc_jal: begin
                // ALU forms the target PC+imm; rd gets PC+4
                w_legal          = 1'b1;
                ctrl.sext_sel    = c_sext_j;
                ctrl.reg_we      = 1'b1;
                ctrl.sel_rs1_pc  = 1'b1;
                ctrl.sel_rs2_imm = 1'b1;
                ctrl.wb_sel      = c_wb_pc4;
                ctrl.npc_sel     = c_npc_jal;
            end
            c_opc_jalr: begin
                w_legal          = (w_f3 == 3'b000);
                ctrl.sext_sel    = c_sext_i;
                ctrl.reg_we      = 1'b1;
                ctrl.sel_rs2_imm = 1'b1;
                ctrl.wb_sel      = c_wb_pc4;
                ctrl.npc_sel     = c_npc_jalr;
            end
            c_opc_branch: begin
                w_legal       = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                ctrl.alu_op   = c_alu_cmp;
                ctrl.sext_sel = c_sext_b;
                ctrl.npc_sel  = c_npc_br;
            end
            c_opc_load: begin
                case (w_f3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                    3'b011, 3'b110:                         w_legal = c_rv64;
                    default:                                w_legal = 1'b0;
                endcase
                ctrl.sext_sel    = c_sext_i;
                ctrl.reg_we      = 1'b1;
                ctrl.sel_rs2_imm = 1'b1;
                ctrl.wb_sel      = c_wb_mem;
                ctrl.mem_re      = 1'b1;
                ctrl.mem_size    = w_f3[1:0];
                ctrl.mem_uns     = w_f3[2];
            end
            c_opc_store: begin
                w_legal          = !w_f3[2] && ((w_f3[1:0] != 2'b11) || c_rv64);
                ctrl.sext_sel    = c_sext_s;
                ctrl.sel_rs2_imm = 1'b1;
                ctrl.mem_we      = 1'b1;
                ctrl.mem_size    = w_f3[1:0];
            end
            c_opc_op_imm: begin
                ctrl.alu_op      = alu_of_f3(w_f3);
                ctrl.sext_sel    = c_sext_i;
                ctrl.reg_we      = 1'b1;
                ctrl.sel_rs2_imm = 1'b1;
                // shamt[5] (instr[25]) only exists on RV64
                if (w_f3 == 3'b001) begin
                    w_legal      = (instr[31:26] == 6'b000000) && (c_rv64 || !instr[25]);
                    ctrl.alu_sub = {instr[30], w_f3};
                end else if (w_f3 == 3'b101) begin
                    w_legal      = ((instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000))
                                   && (c_rv64 || !instr[25]);
                    ctrl.alu_sub = {instr[30], w_f3};
                end else begin
                    w_legal = 1'b1;
                end
            end
            c_opc_op_imm32: begin
                ctrl.alu_op      = alu_of_f3(w_f3);
                ctrl.sext_sel    = c_sext_i;
                ctrl.reg_we      = 1'b1;
                ctrl.sel_rs2_imm = 1'b1;
                ctrl.word_op     = 1'b1;
                case (w_f3)
                    3'b000: w_legal = c_rv64;
                    3'b001: begin
                        w_legal      = c_rv64 && (w_f7 == c_f7_base);
                        ctrl.alu_sub = {instr[30], w_f3};
                    end
                    3'b101: begin
                        w_legal      = c_rv64 && ((w_f7 == c_f7_base) || (w_f7 == c_f7_alt));
                        ctrl.alu_sub = {instr[30], w_f3};
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            c_opc_op: begin
                ctrl.alu_op  = alu_of_f3(w_f3);
                ctrl.alu_sub = {instr[30], w_f3};
                ctrl.reg_we  = 1'b1;
                case (w_f7)
                    c_f7_base: w_legal = 1'b1;
                    c_f7_alt:  w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b101);
                    c_f7_muldiv: begin
                        ctrl.alu_op = w_f3[2] ? c_alu_div : c_alu_mul;
                        w_legal     = c_m_ext;
                    end
                    default:   w_legal = 1'b0;
                endcase
            end
            c_opc_op32: begin
                ctrl.alu_op  = (w_f3 == 3'b000) ? c_alu_add : c_alu_shift;
                ctrl.alu_sub = {instr[30], w_f3};
                ctrl.reg_we  = 1'b1;
                ctrl.word_op = 1'b1;
                case (w_f7)
                    c_f7_base: w_legal = c_rv64 && ((w_f3 == 3'b000) || (w_f3 == 3'b001)
                                                    || (w_f3 == 3'b101));
                    c_f7_alt:  w_legal = c_rv64 && ((w_f3 == 3'b000) || (w_f3 == 3'b101));
                    c_f7_muldiv: begin
                        ctrl.alu_op = w_f3[2] ? c_alu_div : c_alu_mul;
                        w_legal     = c_m_ext && c_rv64 && ((w_f3 == 3'b000) || w_f3[2]);
                    end
                    default:   w_legal = 1'b0;
                endcase
            end
            c_opc_system: begin
                w_legal     = (instr == c_instr_ebreak);
                ctrl.alu_op = c_alu_none;
                ctrl.ebreak = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase

        if (!w_legal) begin
            ctrl         = '0;
            ctrl.alu_op  = c_alu_none;
            ctrl.illegal = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/idu_ctrl_stage.sv
`default_nettype none
// ============================================================================
//  Module      : idu_ctrl_stage
//  Description : Registered decode stage between IFU and EXU. Valid/ready on
//                both sides, flush from redirect, and a MUL/DIV wait state
//                that back-pressures fetch (present only with RV_M_EXT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module idu_ctrl_stage
    import idu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [3:0]      alu_op,
    output logic [3:0]      alu_sub,
    output logic [2:0]      sext_sel,
    output logic            reg_we,
    output logic            sel_rs1_pc,
    output logic            sel_rs2_imm,
    output logic [1:0]      wb_sel,
    output logic [1:0]      npc_sel,
    output logic            mem_re,
    output logic            mem_we,
    output logic [1:0]      mem_size,
    output logic            mem_uns,
    output logic            word_op,
    output logic            illegal,
    output logic            ebreak
);

    ctrl_t           w_dec;
    ctrl_t           r_ctrl;
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            w_idle;
    logic            w_in_fire;
    logic            w_out_fire;

    idu_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr (in_instr),
        .ctrl  (w_dec)
    );

    assign in_ready   = !flush && w_idle && (!r_valid || out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_valid && out_ready;

    // Pipeline register: capture on input transfer, drain on output transfer, flush wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_dec;
            r_pc    <= in_pc;
            r_instr <= in_instr;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

`ifdef RV_M_EXT_EN
    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_WAIT_MD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_mul_load = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_div_load = CNT_W'(DIV_LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // MUL/DIV wait state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Stall fetch for LAT-1 cycles after a MUL/DIV leaves towards the EXU
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            if (r_state == S_WAIT_MD) begin
                w_cnt_nxt = r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    w_state_nxt = S_IDLE;
                end
            end
            if (w_out_fire && (r_ctrl.alu_op == c_alu_mul) && (MUL_LAT > 1)) begin
                w_state_nxt = S_WAIT_MD;
                w_cnt_nxt   = c_mul_load;
            end else if (w_out_fire && (r_ctrl.alu_op == c_alu_div) && (DIV_LAT > 1)) begin
                w_state_nxt = S_WAIT_MD;
                w_cnt_nxt   = c_div_load;
            end
        end
    end

    assign w_idle = (r_state == S_IDLE);
`else
    // No multi-cycle ops exist without the M extension, so fetch is never stalled
    logic w_unused_cfg;
    assign w_unused_cfg = (MUL_LAT + DIV_LAT + CNT_W) > 0;
    assign w_idle       = 1'b1;
`endif

    assign out_valid   = r_valid;
    assign out_pc      = r_pc;
    assign out_instr   = r_instr;
    assign alu_op      = r_ctrl.alu_op;
    assign alu_sub     = r_ctrl.alu_sub;
    assign sext_sel    = r_ctrl.sext_sel;
    assign reg_we      = r_ctrl.reg_we;
    assign sel_rs1_pc  = r_ctrl.sel_rs1_pc;
    assign sel_rs2_imm = r_ctrl.sel_rs2_imm;
    assign wb_sel      = r_ctrl.wb_sel;
    assign npc_sel     = r_ctrl.npc_sel;
    assign mem_re      = r_ctrl.mem_re;
    assign mem_we      = r_ctrl.mem_we;
    assign mem_size    = r_ctrl.mem_size;
    assign mem_uns     = r_ctrl.mem_uns;
    assign word_op     = r_ctrl.word_op;
    assign illegal     = r_ctrl.illegal;
    assign ebreak      = r_ctrl.ebreak;

endmodule
`default_nettype wire
